ssd_driver: RTL
===============

# ssd_driver

Sequential display back-end for the CPU's 13-bit seven-segment debug bus. On a load pulse it captures a binary value (0–8191) and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a 4-digit common-anode display with active-low anodes and segments. It sits between the CPU top-level debug mux and the board display pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit; legal minimum 1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `value` in 13: unsigned binary value to display.
- `load` in 1: single-cycle request to capture `value` and convert it.
- `busy` out 1: conversion in progress; `load` is ignored while high.
- `anode` out 4: digit enables, active-low; `anode[0]` is the ones digit (rightmost), `anode[3]` is the thousands digit.
- `seg` out 7: segments, active-low, ordered {g,f,e,d,c,b,a}.

## Operation
- FSM with two states, IDLE and CONVERT. Reset state is IDLE.
- In IDLE with `load`=1 at an edge: latch `value` into the low 13 bits of a 29-bit shift register {bcd[15:0], bin[12:0]}, clear bcd, set the iteration counter to 0, and move to CONVERT.
- Each CONVERT cycle, in this order:
  - Add 3 to every bcd nibble that is ≥5.
  - Shift the whole register left by 1.
  - Increment the counter.
- When counter = 12 (the 13th iteration): write the final bcd into the display digit register and return to IDLE.
- `value` changes after capture have no effect on the conversion in progress.
- `load` during CONVERT is dropped. There is no queueing.
- The display digit register updates only on conversion completion. It holds its old content throughout a conversion, so the display never shows a partial result.
- Leading zeros are shown; there is no blanking. The maximum thousands digit is 8.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - `anode` = ~(1 << index).
  - `seg` = font(digit[index]).
- BCD font, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10–15 cannot occur; they map to 1111111 (blank).

## Timing
- Reset values: `busy`=0, `anode`=1110, `seg`=1000000, digits=0000, digit index=0, refresh counter=0, FSM=IDLE.
- `load` is sampled at edge k.
- `busy` is high after edge k through edge k+13, which is 13 cycles.
- New digits are visible after edge k+13. `busy` is low after that same edge.
- A `load` at edge k+13 is ignored because the FSM is still in CONVERT. A `load` at edge k+14 is accepted.
- Throughput: one conversion per 14 cycles at most.
- `anode` and `seg` are registered outputs. They change only at refresh-counter terminal count or when the display digit register updates.
- With REFRESH_DIV=1, the index advances every cycle.
- Mid-operation reset: all state returns to reset values immediately (asynchronously). Any conversion in progress is aborted and its result is discarded.
- The refresh counter is $clog2(REFRESH_DIV) bits wide, with a minimum of 1 bit.

## Structure
- Shared package `ssd_pkg`:
  - `SSD_VALUE_W`=13, `BCD_DIGITS`=4.
  - Segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - Function `bcd_to_seg`.
- One sub-module, `bin2bcd_seq`:
  - Contains the FSM, the 29-bit shift register, and the 4-bit iteration counter.
  - Ports: `clk`, `rst`, `start`, `bin`, `busy`, `done`, `bcd[15:0]`.
  - `done` pulses on the completion edge.
- `ssd_driver` contains the display digit register, the refresh counter, the digit index, and the output registers.

## Test plan
- Reset: hold `rst`=0 mid-run → `busy`=0, `anode`=1110, `seg`=1000000 immediately, without waiting for a clock edge.
- REFRESH_DIV=4, `load` with `value`=1234 → `busy` high for exactly 13 cycles. Digits are then 1,2,3,4, shown as `anode` 1110 with `seg`=0011001, then 1101 with 0110000, then 1011 with 0100100, then 0111 with 1111001.
- `value`=8191 → digits 8,1,9,1. `value`=0 → 0,0,0,0. `value`=9 → 0,0,0,9 with `seg` 0010000 on `anode` 1110.
- `load` 4321, then `load` 5555 with `value` changed on cycle 5, then `load` at completion edge k+13 → final digits are 4,3,2,1. A `load` at k+14 is accepted.
- Reset asserted on cycle 6 of converting 7777, then `load` 42 → display reads 0000 during reset, then 0042 after 13 cycles; 7777 never appears.
- REFRESH_DIV=3 → `anode` cycles 1110→1101→1011→0111→1110, changing every 3 cycles with no glitches.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared widths, segment encodings and BCD font for the seven-segment driver.
// Segments are active-low and ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

   localparam int SSD_VALUE_W = 13;
   localparam int BCD_DIGITS  = 4;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {IDLE, CONVERT} conv_state_t;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) converter: one bit per cycle, 13 cycles.
// bcd carries the post-iteration result so the final value is usable on the done edge.
module bin2bcd_seq
   import ssd_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [SSD_VALUE_W-1:0]    bin,
   output logic                      busy,
   output logic                      done,
   output logic [4*BCD_DIGITS-1:0]   bcd
);

   localparam int          SR_W      = 4*BCD_DIGITS + SSD_VALUE_W;
   localparam logic [3:0]  LAST_ITER = 4'(SSD_VALUE_W - 1);

   conv_state_t      state;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_adj;
   logic [SR_W-1:0]  sr_next;
   logic [3:0]       iter;

   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (sr[SSD_VALUE_W + 4*i +: 4] >= 4'd5)
            sr_adj[SSD_VALUE_W + 4*i +: 4] = sr[SSD_VALUE_W + 4*i +: 4] + 4'd3;
      end
      sr_next = {sr_adj[SR_W-2:0], 1'b0};
   end

   assign busy = (state == CONVERT);
   assign done = busy && (iter == LAST_ITER);
   assign bcd  = sr_next[SR_W-1 -: 4*BCD_DIGITS];

   // Loads are only honoured in IDLE; a load arriving mid-conversion is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sr    <= '0;
         iter  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sr    <= {{(4*BCD_DIGITS){1'b0}}, bin};
                  iter  <= '0;
                  state <= CONVERT;
               end
            end
            CONVERT: begin
               sr   <= sr_next;
               iter <= iter + 4'd1;
               if (done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ssd_driver.sv
// Four-digit common-anode display driver: converts a 13-bit value to BCD and
// time-multiplexes the digits with active-low anodes and segments.
module ssd_driver
   import ssd_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SSD_VALUE_W-1:0]  value,
   input  logic                    load,
   output logic                    busy,
   output logic [3:0]              anode,
   output logic [6:0]              seg
);

   localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic                     done;
   logic [4*BCD_DIGITS-1:0]  bcd;
   logic [4*BCD_DIGITS-1:0]  digits;
   logic [4*BCD_DIGITS-1:0]  digits_next;
   logic [CNT_W-1:0]         rcnt;
   logic [1:0]               idx;
   logic [1:0]               idx_next;
   logic                     tc;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (load),
      .bin   (value),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   assign tc          = (rcnt == CNT_LAST);
   assign idx_next    = tc ? idx + 2'd1 : idx;
   assign digits_next = done ? bcd : digits;

   // Outputs are registered from the next-state values so a new digit set or
   // index shows up on the same edge that produces it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rcnt   <= '0;
         idx    <= '0;
         digits <= '0;
         anode  <= 4'b1110;
         seg    <= SEG_0;
      end else begin
         rcnt   <= tc ? '0 : rcnt + 1'b1;
         idx    <= idx_next;
         digits <= digits_next;
         anode  <= ~(4'b0001 << idx_next);
         seg    <= bcd_to_seg(digits_next[{idx_next, 2'b00} +: 4]);
      end
   end

endmodule
